wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs and selects the write-back value (load data or ALU result). It commits that value into a 32 x 32-bit register file and serves the two decode-stage read ports, with same-cycle write-to-read bypass. It also keeps a retired-write counter and a last-commit record for debug and bench scoreboarding.

## Interface
Parameters:
- DATA_W, 32, register and data width
- NREGS, 32, number of architectural registers (address width = log2(NREGS) = 5)

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_data_in  in  32  load data from MEM/WB
- alu_result_in  in  32  ALU result from MEM/WB
- reg_dest_in  in  5  destination register from MEM/WB
- MemToReg_in  in  1  1 selects mem_data_in, 0 selects alu_result_in
- RegWrite_in  in  1  write enable from MEM/WB
- rs_addr  in  5  decode read port A address
- rt_addr  in  5  decode read port B address
- rs_data  out  32  read port A data (combinational)
- rt_data  out  32  read port B data (combinational)
- wb_data  out  32  selected write-back value (combinational, for EX forwarding)
- wb_valid  out  1  RegWrite_in && reg_dest_in != 0 (combinational)
- retired_count  out  32  count of committed writes
- last_dest  out  5  destination of most recent commit
- last_data  out  32  value of most recent commit

## Operation
- wb_data = MemToReg_in ? mem_data_in : alu_result_in.
- Commit: on a rising clock edge with wb_valid = 1, regs[reg_dest_in] <= wb_data. In the same edge, last_dest <= reg_dest_in, last_data <= wb_data, and retired_count increments.
- Register 0 is hardwired to zero. A write to it with RegWrite_in = 1 is discarded: no array change, no counter increment, last_* unchanged. Reads of address 0 return 0.
- Read port A:
  - rs_addr == 0 -> 0
  - else if wb_valid && rs_addr == reg_dest_in -> wb_data (bypass)
  - else regs[rs_addr]
- Port B is identical, using rt_addr.
- Both ports may read the same address. They may also both match the pending write; both then return wb_data.
- retired_count wraps from 0xFFFFFFFF to 0 with no flag.
- Reset (reset_n low, asynchronous, takes effect immediately): all regs, retired_count, last_dest and last_data go to 0.
  - rs_data, rt_data, wb_data and wb_valid stay combinational functions of the inputs and the cleared state.
  - A commit edge coinciding with asserted reset is lost.
  - Reset deasserted mid-stream: the first commit happens on the first rising edge with reset_n high.
- No stall or flush input. The upstream stage squashes a write by driving RegWrite_in = 0.

## Timing
- Write latency: 1 edge. A value presented with wb_valid in cycle N appears in regs after edge N.
- Read latency: 0. Because of the bypass, decode sees the cycle-N write in cycle N, so the pipeline needs no extra WB-to-ID hazard stall.
- MEM/WB launches on the falling edge. Its outputs therefore have half a cycle to settle before the commit edge, and the bypass path must fit in that half-cycle plus decode.
- No handshake: every cycle with wb_valid = 1 commits exactly one write.

## Test plan
- Reset with reset_n = 0, then read all 32 addresses on both ports -> all read 0; retired_count = 0.
- ALU write: RegWrite = 1, MemToReg = 0, dest = 5, alu = 0x1234_5678, mem = 0xDEAD_BEEF.
  - Same cycle: rs_addr = 5 reads 0x1234_5678 via bypass.
  - After the edge: regs[5] = 0x1234_5678, retired_count = 1, last_dest = 5.
- Load write: MemToReg = 1, dest = 31, mem = 0xCAFE_F00D -> after the edge, rt_addr = 31 reads 0xCAFE_F00D.
- Write to $0: RegWrite = 1, dest = 0, alu = 0xFFFF_FFFF.
  - rs_addr = 0 reads 0 in the same cycle and after the edge.
  - wb_valid = 0; retired_count and last_* are unchanged.
- Squash and overwrite:
  - Write dest = 7 with 0xAAAA_AAAA.
  - Next cycle, RegWrite = 0, dest = 7, alu = 0x5555_5555 -> regs[7] stays 0xAAAA_AAAA.
  - Then write 0x0000_0001 to dest 7 -> both ports at address 7 read 0x0000_0001 in the bypass cycle and after.
- Asynchronous reset mid-stream:
  - After several writes, pull reset_n low between clock edges -> all outputs from the register array and counters read 0 immediately.
  - Preload retired_count to 0xFFFF_FFFF by force, then do one write -> count reads 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back select and 32x32 register file with same-cycle WB->ID bypass; $0 reads as zero.
// Latency: commit on 1 rising edge, reads are combinational; no backpressure, every wb_valid cycle commits.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [AW-1:0]     reg_dest_in,
  input  logic              MemToReg_in,
  input  logic              RegWrite_in,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic [31:0]       retired_count,
  output logic [AW-1:0]     last_dest,
  output logic [DATA_W-1:0] last_data
);

  logic [DATA_W-1:0] regs [NREGS];

  assign wb_data  = MemToReg_in ? mem_data_in : alu_result_in;
  assign wb_valid = RegWrite_in && (reg_dest_in != '0);

  // Writes to $0 never reach the array, so regs[0] stays at its reset value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      retired_count <= '0;
      last_dest     <= '0;
      last_data     <= '0;
    end else if (wb_valid) begin
      regs[reg_dest_in] <= wb_data;
      retired_count     <= retired_count + 32'd1;
      last_dest         <= reg_dest_in;
      last_data         <= wb_data;
    end
  end

  // Bypass lets decode see this cycle's commit without a WB->ID hazard stall.
  assign rs_data = (rs_addr == '0) ? '0 :
                   (wb_valid && (rs_addr == reg_dest_in)) ? wb_data : regs[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 :
                   (wb_valid && (rt_addr == reg_dest_in)) ? wb_data : regs[rt_addr];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass, $0 handling, squash, async reset, counter wrap.
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] mem_data_in = '0;
  logic [31:0] alu_result_in = '0;
  logic [4:0]  reg_dest_in = '0;
  logic        MemToReg_in = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        wb_valid;
  logic [31:0] retired_count;
  logic [4:0]  last_dest;
  logic [31:0] last_data;

  int checks = 0;
  int failures = 0;

  wb_regfile dut (
    .clock(clock), .reset_n(reset_n),
    .mem_data_in(mem_data_in), .alu_result_in(alu_result_in),
    .reg_dest_in(reg_dest_in), .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data), .wb_valid(wb_valid),
    .retired_count(retired_count), .last_dest(last_dest), .last_data(last_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge, like the MEM/WB register.
  task automatic drive(input logic rw, input logic m2r, input logic [4:0] dst,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clock);
    RegWrite_in = rw; MemToReg_in = m2r; reg_dest_in = dst;
    alu_result_in = alu; mem_data_in = mem; rs_addr = ra; rt_addr = rb;
    #1;
  endtask

  task automatic edge_wait;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset and scan every address on both ports
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    for (int a = 0; a < 32; a++) begin
      rs_addr = a[4:0];
      rt_addr = 5'(31 - a);
      #1;
      chk($sformatf("reset_rs_%0d", a), rs_data, 32'h0);
      chk($sformatf("reset_rt_%0d", 31 - a), rt_data, 32'h0);
    end
    chk("reset_count", retired_count, 32'h0);
    chk("reset_last_dest", {27'b0, last_dest}, 32'h0);
    chk("reset_last_data", last_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // ALU write to $5 with bypass
    drive(1'b1, 1'b0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF, 5'd5, 5'd5);
    chk("alu_wb_data", wb_data, 32'h1234_5678);
    chk("alu_wb_valid", {31'b0, wb_valid}, 32'h1);
    chk("alu_bypass_rs", rs_data, 32'h1234_5678);
    chk("alu_bypass_rt", rt_data, 32'h1234_5678);
    edge_wait();
    chk("alu_count", retired_count, 32'd1);
    chk("alu_last_dest", {27'b0, last_dest}, 32'd5);
    chk("alu_last_data", last_data, 32'h1234_5678);
    drive(1'b0, 1'b0, 5'd5, 32'h0, 32'h0, 5'd5, 5'd6);
    chk("alu_stored_rs5", rs_data, 32'h1234_5678);
    chk("alu_untouched_rt6", rt_data, 32'h0);

    // Load write to $31
    drive(1'b1, 1'b1, 5'd31, 32'h0BAD_0BAD, 32'hCAFE_F00D, 5'd5, 5'd31);
    chk("load_wb_data", wb_data, 32'hCAFE_F00D);
    chk("load_bypass_rt", rt_data, 32'hCAFE_F00D);
    chk("load_other_rs5", rs_data, 32'h1234_5678);
    edge_wait();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
    chk("load_stored_rt31", rt_data, 32'hCAFE_F00D);
    chk("load_count", retired_count, 32'd2);
    chk("load_last_dest", {27'b0, last_dest}, 32'd31);

    // Write to $0 is discarded
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0);
    chk("zero_wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("zero_wb_data", wb_data, 32'hFFFF_FFFF);
    chk("zero_rs_same_cycle", rs_data, 32'h0);
    chk("zero_rt_same_cycle", rt_data, 32'h0);
    edge_wait();
    chk("zero_rs_after", rs_data, 32'h0);
    chk("zero_count", retired_count, 32'd2);
    chk("zero_last_dest", {27'b0, last_dest}, 32'd31);
    chk("zero_last_data", last_data, 32'hCAFE_F00D);

    // Squash then overwrite $7
    drive(1'b1, 1'b0, 5'd7, 32'hAAAA_AAAA, 32'h0, 5'd7, 5'd0);
    edge_wait();
    drive(1'b0, 1'b0, 5'd7, 32'h5555_5555, 32'h0, 5'd7, 5'd7);
    chk("squash_rs_same_cycle", rs_data, 32'hAAAA_AAAA);
    edge_wait();
    chk("squash_rs_after", rs_data, 32'hAAAA_AAAA);
    chk("squash_count", retired_count, 32'd3);
    drive(1'b1, 1'b0, 5'd7, 32'h0000_0001, 32'h0, 5'd7, 5'd7);
    chk("over_bypass_rs", rs_data, 32'h0000_0001);
    chk("over_bypass_rt", rt_data, 32'h0000_0001);
    edge_wait();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
    chk("over_stored_rs", rs_data, 32'h0000_0001);
    chk("over_stored_rt", rt_data, 32'h0000_0001);
    chk("over_count", retired_count, 32'd4);
    chk("over_last_data", last_data, 32'h0000_0001);

    // Asynchronous reset between edges
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
    chk("pre_arst_rs5", rs_data, 32'h1234_5678);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_rs5", rs_data, 32'h0);
    chk("arst_rt31", rt_data, 32'h0);
    chk("arst_count", retired_count, 32'h0);
    chk("arst_last_dest", {27'b0, last_dest}, 32'h0);
    chk("arst_last_data", last_data, 32'h0);

    // A commit edge during reset is lost; bypass stays combinational
    drive(1'b1, 1'b0, 5'd9, 32'h0000_0099, 32'h0, 5'd9, 5'd9);
    chk("inrst_bypass_rs9", rs_data, 32'h0000_0099);
    edge_wait();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd7);
    chk("inrst_lost_rs9", rs_data, 32'h0);
    chk("inrst_rt7", rt_data, 32'h0);
    chk("inrst_count", retired_count, 32'h0);
    reset_n = 1'b1;

    // Counter wrap from all-ones
    @(negedge clock);
    force dut.retired_count = 32'hFFFF_FFFF;
    #1 release dut.retired_count;
    #1;
    chk("wrap_preload", retired_count, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 5'd3, 32'h0000_0003, 32'h0, 5'd3, 5'd0);
    edge_wait();
    chk("wrap_count", retired_count, 32'h0);
    chk("wrap_last_dest", {27'b0, last_dest}, 32'd3);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
    chk("wrap_stored_rs3", rs_data, 32'h0000_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
